// File: rtl/cu_pkg.sv
// Shared control-unit constants: FSM state codes, instruction classes and control-field encodings.
// Used by both the single-cycle and multicycle control units. Purely declarative, so no latency or backpressure.
package cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5
    } state_e;

    typedef enum logic [4:0] {
        CLS_NOP, CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LW, CLS_LB, CLS_SW, CLS_BEQ,
        CLS_LUI, CLS_JAL, CLS_JR, CLS_SLL, CLS_SLT,
        CLS_MULT, CLS_MULTU, CLS_DIV, CLS_DIVU
    } cls_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [3:0] NPC_NORMAL = 4'd0;
    localparam logic [3:0] NPC_BRANCH = 4'd1;
    localparam logic [3:0] NPC_J      = 4'd2;
    localparam logic [3:0] NPC_JR     = 4'd3;

    localparam logic [3:0] DM_W = 4'd0;
    localparam logic [3:0] DM_B = 4'd1;
    localparam logic [3:0] DM_H = 4'd2;

    localparam logic [3:0] GRF_NORMAL = 4'd0;
    localparam logic [3:0] GRF_LINK   = 4'd1;

    localparam logic [3:0] EXT_ZERO = 4'd0;
    localparam logic [3:0] EXT_SIGN = 4'd1;
    localparam logic [3:0] EXT_LUI  = 4'd2;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_SLL   = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_PASSB = 4'd5;

    localparam logic [3:0] CMP_NONE = 4'd0;
    localparam logic [3:0] CMP_EQ   = 4'd1;

    localparam logic [2:0] RIN_ALU   = 3'd0;
    localparam logic [2:0] RIN_DMOUT = 3'd1;
    localparam logic [2:0] RIN_PC    = 3'd2;

    localparam logic [2:0] RA3_RD = 3'd0;
    localparam logic [2:0] RA3_RT = 3'd1;
    localparam logic [2:0] RA3_RA = 3'd2;

    localparam logic [2:0] SRCB_REG   = 3'd0;
    localparam logic [2:0] SRCB_IMM   = 3'd1;
    localparam logic [2:0] SRCB_SHAMT = 3'd2;

    function automatic logic is_mdu(input cls_e c);
        return (c == CLS_MULT) || (c == CLS_MULTU) || (c == CLS_DIV) || (c == CLS_DIVU);
    endfunction

    function automatic logic is_div(input cls_e c);
        return (c == CLS_DIV) || (c == CLS_DIVU);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode/funct to instruction-class decode; zero latency, no backpressure.
// MDU encodings decode only when MULTICYCLE_MDU_EN is defined, otherwise they fall to nop.
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funcode_i,
    output cls_e       cls_o
);

    always_comb begin
        cls_o = CLS_NOP;
        case (opcode_i)
            OP_RTYPE: begin
                case (funcode_i)
                    FN_ADDU:  cls_o = CLS_ADDU;
                    FN_SUBU:  cls_o = CLS_SUBU;
                    FN_SLL:   cls_o = CLS_SLL;
                    FN_SLT:   cls_o = CLS_SLT;
                    FN_JR:    cls_o = CLS_JR;
`ifdef MULTICYCLE_MDU_EN
                    FN_MULT:  cls_o = CLS_MULT;
                    FN_MULTU: cls_o = CLS_MULTU;
                    FN_DIV:   cls_o = CLS_DIV;
                    FN_DIVU:  cls_o = CLS_DIVU;
`endif
                    default:  cls_o = CLS_NOP;
                endcase
            end
            OP_ORI:  cls_o = CLS_ORI;
            OP_LW:   cls_o = CLS_LW;
            OP_LB:   cls_o = CLS_LB;
            OP_SW:   cls_o = CLS_SW;
            OP_BEQ:  cls_o = CLS_BEQ;
            OP_LUI:  cls_o = CLS_LUI;
            OP_JAL:  cls_o = CLS_JAL;
            default: cls_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/MDU_WAIT); outputs are combinational from state.
// FETCH and MEM stall on mem_ready; optional MDU wait state enabled by MULTICYCLE_MDU_EN.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funcode,
    input  logic       CMPOut,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic [3:0] NPCOP,
    output logic       IorD,
    output logic       mem_req,
    output logic       MemWrite,
    output logic [3:0] DMOP,
    output logic       RegWrite,
    output logic [3:0] GRFOP,
    output logic [3:0] EXTOP,
    output logic [3:0] ALUOP,
    output logic [3:0] CMPOP,
    output logic [2:0] RegInSel,
    output logic [2:0] RegAdd3Sel,
    output logic [2:0] SrcBSel,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic       instr_done
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    state_e        state_q, state_d;
    cls_e          cls_q, cls_d;
    cls_e          dec_cls, cur_cls;
    logic [CW-1:0] cnt_q, cnt_d;

    cu_decode u_decode (
        .opcode_i  (opcode),
        .funcode_i (funcode),
        .cls_o     (dec_cls)
    );

    // The class is only valid from the IR in DECODE; later states use the latched copy.
    assign cur_cls = (state_q == S_DECODE) ? dec_cls : cls_q;
    assign state   = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    CLS_JAL, CLS_JR, CLS_NOP: state_d = S_FETCH;
                    default:                  state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_BEQ:               state_d = S_FETCH;
                    CLS_LW, CLS_LB, CLS_SW: state_d = S_MEM;
                    default:               state_d = S_WB;
                endcase
`ifdef MULTICYCLE_MDU_EN
                if (is_mdu(cls_q)) begin
                    state_d = S_MDU_WAIT;
                    cnt_d   = is_div(cls_q) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                end
`endif
            end
            S_MEM: begin
                if (mem_ready) state_d = (cls_q == CLS_SW) ? S_FETCH : S_WB;
            end
            S_WB: state_d = S_FETCH;
            S_MDU_WAIT: begin
                if (cnt_q <= CW'(1)) state_d = S_FETCH;
`ifdef MULTICYCLE_MDU_EN
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        NPCOP      = NPC_NORMAL;
        IorD       = 1'b0;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        DMOP       = DM_W;
        RegWrite   = 1'b0;
        GRFOP      = GRF_NORMAL;
        EXTOP      = EXT_ZERO;
        ALUOP      = ALU_ADD;
        CMPOP      = CMP_NONE;
        RegInSel   = RIN_ALU;
        RegAdd3Sel = RA3_RD;
        SrcBSel    = SRCB_REG;
        mdu_start  = 1'b0;
        mdu_busy   = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_DECODE: begin
                case (cur_cls)
                    CLS_JAL: begin
                        PCWrite    = 1'b1;
                        NPCOP      = NPC_J;
                        RegWrite   = 1'b1;
                        RegInSel   = RIN_PC;
                        RegAdd3Sel = RA3_RA;
                        GRFOP      = GRF_LINK;
                        instr_done = 1'b1;
                    end
                    CLS_JR: begin
                        PCWrite    = 1'b1;
                        NPCOP      = NPC_JR;
                        instr_done = 1'b1;
                    end
                    CLS_NOP: instr_done = 1'b1;
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (cur_cls)
                    CLS_SUBU: ALUOP = ALU_SUB;
                    CLS_SLT:  ALUOP = ALU_SLT;
                    CLS_SLL: begin
                        ALUOP   = ALU_SLL;
                        SrcBSel = SRCB_SHAMT;
                    end
                    CLS_ORI: begin
                        ALUOP   = ALU_OR;
                        SrcBSel = SRCB_IMM;
                    end
                    CLS_LUI: begin
                        ALUOP   = ALU_PASSB;
                        EXTOP   = EXT_LUI;
                        SrcBSel = SRCB_IMM;
                    end
                    CLS_LW, CLS_LB, CLS_SW: begin
                        EXTOP   = EXT_SIGN;
                        SrcBSel = SRCB_IMM;
                    end
                    CLS_BEQ: begin
                        ALUOP      = ALU_SUB;
                        EXTOP      = EXT_SIGN;
                        CMPOP      = CMP_EQ;
                        PCWrite    = CMPOut;
                        NPCOP      = NPC_BRANCH;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
`ifdef MULTICYCLE_MDU_EN
                mdu_start = is_mdu(cur_cls);
`endif
            end
            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = (cur_cls == CLS_SW);
                DMOP     = (cur_cls == CLS_LB) ? DM_B : DM_W;
                if (mem_ready && cur_cls == CLS_SW) instr_done = 1'b1;
            end
            S_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                DMOP       = (cur_cls == CLS_LB) ? DM_B : DM_W;
                case (cur_cls)
                    CLS_LW, CLS_LB: begin
                        RegInSel   = RIN_DMOUT;
                        RegAdd3Sel = RA3_RT;
                    end
                    CLS_ORI, CLS_LUI: RegAdd3Sel = RA3_RT;
                    default:          RegAdd3Sel = RA3_RD;
                endcase
            end
            S_MDU_WAIT: begin
`ifdef MULTICYCLE_MDU_EN
                mdu_busy   = 1'b1;
                instr_done = (cnt_q <= CW'(1));
`endif
            end
            default: ;
        endcase
        // Strobes are forced low while reset is held so nothing fires during an abort.
        if (!reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            mdu_start  = 1'b0;
            mdu_busy   = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
